// File: rtl/dqdbp_mac_seq.sv
// dqdbp_mac_seq: time-shared row engine for the dqd backward pass (acc + M^T*v)
// and the Minv step (M*v); one result row per cycle, valid/ready on both sides.
module dqdbp_mac_seq #(
  parameter int WIDTH        = 32,
  parameter int DECIMAL_BITS = 16,
  parameter int DIM          = 7,
  parameter int TAU_IDX      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     minv,
  input  logic [DIM*DIM*WIDTH-1:0] mat_in,
  input  logic [DIM*WIDTH-1:0]     vec_in,
  input  logic [DIM*WIDTH-1:0]     acc_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIM*WIDTH-1:0]     vec_out,
  output logic [WIDTH-1:0]         dtau_out
);

  localparam int ROW_W = $clog2(DIM);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef logic [WIDTH-1:0] word_t;

  state_e           state_q;
  logic [ROW_W-1:0] row_q;
  word_t            mat_q [DIM][DIM];  // [row][col]
  word_t            vec_q [DIM];
  word_t            acc_q [DIM];
  logic             minv_q;
  word_t            res_q [DIM];
  word_t            dtau_q;
  word_t            row_d;
  word_t            coef;
  logic             accept;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  // Full-width signed product, floor-shifted back to the fixed-point scale.
  function automatic word_t fxmul(input word_t a, input word_t b);
    logic signed [2*WIDTH-1:0] a_x, b_x, p;
    a_x = {{WIDTH{a[WIDTH-1]}}, a};
    b_x = {{WIDTH{b[WIDTH-1]}}, b};
    p   = a_x * b_x;
    p   = p >>> DECIMAL_BITS;
    return p[WIDTH-1:0];
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    coef  = '0;
    row_d = minv_q ? '0 : acc_q[row_q];
    for (int c = 0; c < DIM; c++) begin
      coef  = minv_q ? mat_q[row_q][c] : mat_q[c][row_q];
      row_d = row_d + fxmul(coef, vec_q[c]);
    end
  end

  // NOTE: operand storage is deliberately not reset; it is only read after an accept loads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      minv_q <= minv;
      for (int r = 0; r < DIM; r++) begin
        vec_q[r] <= vec_in[r*WIDTH +: WIDTH];
        acc_q[r] <= acc_in[r*WIDTH +: WIDTH];
        for (int c = 0; c < DIM; c++) begin
          mat_q[r][c] <= mat_in[(c*DIM+r)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so edge ordering never matters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      dtau_q  <= '0;
      for (int r = 0; r < DIM; r++) res_q[r] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            dtau_q  <= vec_in[TAU_IDX*WIDTH +: WIDTH];
            row_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q[row_q] <= row_d;
          row_q        <= row_q + ROW_W'(1);
          if (row_q == ROW_W'(DIM-1)) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < DIM; k++) begin : g_pack
    assign vec_out[k*WIDTH +: WIDTH] = res_q[k];
  end
  assign dtau_out = dtau_q;

endmodule

// File: tb/tb_dqdbp_mac_seq.sv
// Bench for dqdbp_mac_seq: directed and random jobs against a behavioural model,
// plus an identity run on a narrower DIM=6 / WIDTH=24 instance.
module tb_dqdbp_mac_seq;

  localparam int W  = 32, FB  = 16, N  = 7, T  = 2;
  localparam int W2 = 24, FB2 = 12, N2 = 6, T2 = 2;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0, minv = 1'b0, out_ready = 1'b0;
  logic               in_ready, out_valid;
  logic [N*N*W-1:0]   mat_in = '0;
  logic [N*W-1:0]     vec_in = '0, acc_in = '0;
  logic [N*W-1:0]     vec_out;
  logic [W-1:0]       dtau_out;

  logic               b_in_valid = 1'b0, b_minv = 1'b1, b_out_ready = 1'b0;
  logic               b_in_ready, b_out_valid;
  logic [N2*N2*W2-1:0] b_mat = '0;
  logic [N2*W2-1:0]   b_vec = '0, b_acc = '0;
  logic [N2*W2-1:0]   b_vec_out;
  logic [W2-1:0]      b_dtau;

  dqdbp_mac_seq #(.WIDTH(W), .DECIMAL_BITS(FB), .DIM(N), .TAU_IDX(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .minv(minv),
    .mat_in(mat_in), .vec_in(vec_in), .acc_in(acc_in), .out_valid(out_valid),
    .out_ready(out_ready), .vec_out(vec_out), .dtau_out(dtau_out));

  dqdbp_mac_seq #(.WIDTH(W2), .DECIMAL_BITS(FB2), .DIM(N2), .TAU_IDX(T2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .minv(b_minv),
    .mat_in(b_mat), .vec_in(b_vec), .acc_in(b_acc), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .vec_out(b_vec_out), .dtau_out(b_dtau));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Operands in matrix form; (r,c) is row r, column c.
  logic [31:0] tm [N][N];
  logic [31:0] tv [N];
  logic [31:0] ta [N];

  task automatic clear_ops();
    for (int r = 0; r < N; r++) begin
      tv[r] = '0;
      ta[r] = '0;
      for (int c = 0; c < N; c++) tm[r][c] = '0;
    end
  endtask

  task automatic pack_ops();
    for (int r = 0; r < N; r++) begin
      vec_in[r*W +: W] = tv[r];
      acc_in[r*W +: W] = ta[r];
      for (int c = 0; c < N; c++) mat_in[(c*N+r)*W +: W] = tm[r][c];
    end
  endtask

  function automatic logic [31:0] rnd_word();
    if ($urandom_range(0, 1) == 1) return $urandom;
    return 32'(int'($urandom_range(0, 524288)) - 262144);
  endfunction

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] fxmul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> FB;
    return p[31:0];
  endfunction

  function automatic logic [31:0] exp_row(input int r);
    logic [31:0] s, m;
    s = minv ? 32'h0 : acc_in[r*W +: W];
    for (int c = 0; c < N; c++) begin
      m = minv ? mat_in[(c*N+r)*W +: W] : mat_in[(r*N+c)*W +: W];
      s = s + fxmul(m, vec_in[c*W +: W]);
    end
    return s;
  endfunction

  bit          m_busy = 1'b0;
  bit          m_outv = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_vec [N];
  logic [31:0] m_tau = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_outv <= 1'b0;
      m_cnt  <= 0;
      m_tau  <= '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_tau  <= vec_in[T*W +: W];
        for (int r = 0; r < N; r++) m_vec[r] <= exp_row(r);
      end
    end else if (!m_outv) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == N-1) m_outv <= 1'b1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
      m_outv <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready", in_ready, !m_busy);
      check("out_valid", out_valid, m_outv);
      if (m_outv) begin
        for (int r = 0; r < N; r++)
          check($sformatf("vec_out[%0d]", r), vec_out[r*W +: W], m_vec[r]);
        check("dtau_out", dtau_out, m_tau);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input bit mv);
    int k = 0;
    @(negedge clk);
    pack_ops();
    minv     = mv;
    in_valid = 1'b1;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    minv     = ~minv;
    for (int r = 0; r < N; r++) begin
      vec_in[r*W +: W] = $urandom;
      acc_in[r*W +: W] = $urandom;
      for (int c = 0; c < N; c++) mat_in[(c*N+r)*W +: W] = $urandom;
    end
  endtask

  task automatic wait_out(input int lat_exp);
    int lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, lat_exp);
  endtask

  task automatic release_out(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      for (int r = 0; r < N; r++) vec_in[r*W +: W] = $urandom;
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;  // must not be taken on the same edge as the out handshake
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("in_ready_after_hs", in_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_dtau"}, dtau_out, 32'h0);
    for (int r = 0; r < N; r++) check($sformatf("%s_vec[%0d]", tag, r), vec_out[r*W +: W], 32'h0);
  endtask

  task automatic load_identity();
    clear_ops();
    for (int k = 0; k < N; k++) begin
      tm[k][k] = ONE;
      tv[k]    = 32'(k + 1) << 16;
      ta[k]    = $urandom;
    end
  endtask

  task automatic check_identity(input string tag);
    for (int k = 0; k < N; k++)
      check($sformatf("%s[%0d]", tag, k), vec_out[k*W +: W], 32'(k + 1) << 16);
    check({tag, "_tau"}, dtau_out, 32'h0003_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  logic [31:0] sgn_m [3];
  logic [31:0] sgn_v [3];
  logic [31:0] sgn_r [3];

  initial begin
    sgn_m = '{32'hFFFF_8000, 32'h0000_0001, 32'hFFFF_FFFF};
    sgn_v = '{32'h0003_0000, 32'h0000_0001, 32'h0000_0001};
    sgn_r = '{32'hFFFE_8000, 32'h0000_0000, 32'hFFFF_FFFF};

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    check("b_rst_in_ready", b_in_ready, 1'b1);
    check("b_rst_out_valid", b_out_valid, 1'b0);
    #2 reset = 1'b0;

    // Identity, Minv mode, with 5 cycles of backpressure afterwards.
    load_identity();
    send(1'b1);
    wait_out(N);
    check_identity("ident");
    release_out(5);

    // Transpose-accumulate; v[1] also carries 3.0 so the M*v row 0 picks up M(0,1).
    clear_ops();
    tm[0][1] = 32'h0002_0000;
    tv[0]    = 32'h0003_0000;
    tv[1]    = 32'h0003_0000;
    for (int k = 0; k < N; k++) ta[k] = ONE;
    send(1'b0);
    wait_out(N);
    check("tacc_v1", vec_out[1*W +: W], 32'h0007_0000);
    check("tacc_v0", vec_out[0*W +: W], ONE);
    check("tacc_v6", vec_out[6*W +: W], ONE);
    release_out(0);
    send(1'b1);
    wait_out(N);
    check("mv_v0", vec_out[0*W +: W], 32'h0006_0000);
    check("mv_v1", vec_out[1*W +: W], 32'h0);
    release_out(1);

    // Fixed-point sign and floor truncation.
    for (int i = 0; i < 3; i++) begin
      clear_ops();
      tm[0][0] = sgn_m[i];
      tv[0]    = sgn_v[i];
      send(1'b1);
      wait_out(N);
      check($sformatf("sign%0d", i), vec_out[0*W +: W], sgn_r[i]);
      release_out(0);
    end

    // Accumulate wraps with no saturation.
    clear_ops();
    ta[0]    = 32'h7FFF_0000;
    tm[0][0] = ONE;
    tv[0]    = ONE;
    send(1'b0);
    wait_out(N);
    check("wrap", vec_out[0*W +: W], 32'h8000_0000);
    release_out(0);

    // Reset mid-RUN, off the clock grid, then a fresh job.
    load_identity();
    send(1'b1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    load_identity();
    send(1'b1);
    wait_out(N);
    check_identity("post_abort");
    release_out(2);

    // Random jobs, with in_valid wiggling during RUN and DONE.
    for (int j = 0; j < 40; j++) begin
      clear_ops();
      for (int r = 0; r < N; r++) begin
        tv[r] = rnd_word();
        ta[r] = rnd_word();
        for (int c = 0; c < N; c++) tm[r][c] = rnd_word();
      end
      send(1'($urandom_range(0, 1)));
      in_valid = 1'($urandom_range(0, 1));
      wait_out(N);
      release_out($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Narrow instance: identity with DIM=6, WIDTH=24, DECIMAL_BITS=12.
    begin
      int lat = 0;
      for (int r = 0; r < N2; r++) begin
        b_vec[r*W2 +: W2] = W2'((r + 1) << FB2);
        for (int c = 0; c < N2; c++)
          b_mat[(c*N2+r)*W2 +: W2] = (r == c) ? W2'(1 << FB2) : '0;
      end
      b_minv = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b1;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      b_vec      = '1;
      while (!b_out_valid && lat < 200) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("b_latency", lat, N2);
      for (int k = 0; k < N2; k++)
        check($sformatf("b_ident[%0d]", k), b_vec_out[k*W2 +: W2], 32'((k + 1) << FB2));
      check("b_tau", b_dtau, 32'h0000_3000);
      check("b_in_ready_busy", b_in_ready, 1'b0);
      b_out_ready = 1'b1;
      @(posedge clk);
      #1;
      b_out_ready = 1'b0;
      check("b_in_ready_after_hs", b_in_ready, 1'b1);
      check("b_out_valid_after_hs", b_out_valid, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
